// File: rtl/opcode_text_encoder.sv
// Registered 3-bit opcode to 5-character ASCII mnemonic encoder for the LCD driver.
// Optional single-character read port enabled by defining CODIFICADOR_CHAR_PORT_EN.
module opcode_text_encoder #(
  parameter logic [7:0] PAD_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  opcode,
`ifdef CODIFICADOR_CHAR_PORT_EN
  input  logic [2:0]  char_idx,
  output logic [7:0]  char_out,
`endif
  output logic [39:0] palavra,
  output logic        changed
);

  // Character 0 sits in the low byte, so each literal reads right to left.
  function automatic logic [39:0] encode(input logic [2:0] op);
    logic [39:0] w;
    case (op)
      3'b000:  w = {PAD_CHAR, 8'h44, 8'h41, 8'h4F, 8'h4C};       // LOAD
      3'b001:  w = {PAD_CHAR, PAD_CHAR, 8'h44, 8'h44, 8'h41};    // ADD
      3'b010:  w = {PAD_CHAR, 8'h49, 8'h44, 8'h44, 8'h41};       // ADDI
      3'b011:  w = {PAD_CHAR, PAD_CHAR, 8'h42, 8'h55, 8'h53};    // SUB
      3'b100:  w = {PAD_CHAR, 8'h49, 8'h42, 8'h55, 8'h53};       // SUBI
      3'b101:  w = {PAD_CHAR, PAD_CHAR, 8'h4C, 8'h55, 8'h4D};    // MUL
      3'b110:  w = {8'h52, 8'h41, 8'h45, 8'h4C, 8'h43};          // CLEAR
      default: w = {PAD_CHAR, PAD_CHAR, 8'h4C, 8'h50, 8'h44};    // DPL
    endcase
    return w;
  endfunction

  logic [39:0] nextWord;
  logic [2:0]  lastOpcode;
  logic        loaded;
  logic        nextChanged;

  always_comb begin
    nextWord    = encode(opcode);
    nextChanged = !loaded || (opcode != lastOpcode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      palavra    <= {5{PAD_CHAR}};
      changed    <= 1'b0;
      lastOpcode <= 3'b000;
      loaded     <= 1'b0;
    end else begin
      palavra    <= nextWord;
      changed    <= nextChanged;
      lastOpcode <= opcode;
      loaded     <= 1'b1;
    end
  end

`ifdef CODIFICADOR_CHAR_PORT_EN
  logic [7:0] nextChar;

  // Taken from the word being loaded on the same edge so char_out tracks palavra.
  always_comb begin
    nextChar = PAD_CHAR;
    case (char_idx)
      3'd0:    nextChar = nextWord[7:0];
      3'd1:    nextChar = nextWord[15:8];
      3'd2:    nextChar = nextWord[23:16];
      3'd3:    nextChar = nextWord[31:24];
      3'd4:    nextChar = nextWord[39:32];
      default: nextChar = PAD_CHAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_out <= PAD_CHAR;
    else        char_out <= nextChar;
  end
`endif

endmodule

// File: tb/tb_opcode_text_encoder.sv
// Self-checking bench for opcode_text_encoder: directed cases plus randomized opcodes
// against a string-table reference model.
module tb_opcode_text_encoder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  opcode;
  logic [39:0] palavra;
  logic        changed;
`ifdef CODIFICADOR_CHAR_PORT_EN
  logic [2:0]  char_idx;
  logic [7:0]  char_out;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit       mLoaded;
  bit [2:0] mLast;
  int       pulseCount;

  string names [8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DPL"};

  opcode_text_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
`ifdef CODIFICADOR_CHAR_PORT_EN
    .char_idx (char_idx),
    .char_out (char_out),
`endif
    .palavra  (palavra),
    .changed  (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] expWord(input logic [2:0] op);
    logic [39:0] w;
    string s;
    s = names[op];
    for (int i = 0; i < 5; i++)
      w[i*8 +: 8] = (i < s.len()) ? s[i] : 8'h20;
    return w;
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive opcode (between edges), take one edge, then check on the falling edge.
  task automatic stepCycle(input logic [2:0] op, input string tag);
    logic [39:0] ew;
    bit ec;
`ifdef CODIFICADOR_CHAR_PORT_EN
    logic [7:0] eChar;
`endif
    opcode = op;
    @(posedge clk);
    ew = expWord(op);
    ec = !mLoaded || (op != mLast);
    mLoaded = 1'b1;
    mLast = op;
`ifdef CODIFICADOR_CHAR_PORT_EN
    eChar = (char_idx < 3'd5) ? ew[char_idx*8 +: 8] : 8'h20;
`endif
    @(negedge clk);
    checkVal({tag, "_palavra"}, 64'(palavra), 64'(ew));
    checkVal({tag, "_changed"}, 64'(changed), 64'(ec));
    if (changed) pulseCount++;
`ifdef CODIFICADOR_CHAR_PORT_EN
    checkVal({tag, "_char"}, 64'(char_out), 64'(eChar));
`endif
  endtask

  // Asynchronous reset pulse placed between edges; outputs must drop without a clock.
  task automatic pulseReset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    checkVal({tag, "_rst_palavra"}, 64'(palavra), 64'h2020202020);
    checkVal({tag, "_rst_changed"}, 64'(changed), 64'd0);
`ifdef CODIFICADOR_CHAR_PORT_EN
    checkVal({tag, "_rst_char"}, 64'(char_out), 64'h20);
`endif
    mLoaded = 1'b0;
    mLast = 3'b000;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    opcode = 3'b110;
`ifdef CODIFICADOR_CHAR_PORT_EN
    char_idx = 3'd0;
`endif
    mLoaded = 1'b0;
    mLast = 3'b000;
    pulseCount = 0;

    // Reset value with CLEAR on the input
    @(negedge clk);
    pulseReset("reset");

    // First load and hold
    stepCycle(3'b000, "first");
    for (int i = 0; i < 5; i++) stepCycle(3'b000, "hold");

    // Full sweep from a fresh reset, three cycles per opcode
    @(negedge clk);
    pulseReset("presweep");
    pulseCount = 0;
    for (int op = 0; op < 8; op++)
      for (int k = 0; k < 3; k++) stepCycle(3'(op), "sweep");
    checkVal("sweep_pulses", 64'(pulseCount), 64'd8);

    // Back-to-back changes
    stepCycle(3'b001, "b2b_a");
    stepCycle(3'b011, "b2b_b");
    stepCycle(3'b011, "b2b_c");

    // Reset mid-stream with MUL stable
    for (int i = 0; i < 3; i++) stepCycle(3'b101, "mul");
    pulseReset("mid");
    stepCycle(3'b101, "mid_reload");
    stepCycle(3'b101, "mid_hold");

`ifdef CODIFICADOR_CHAR_PORT_EN
    char_idx = 3'd3;
    stepCycle(3'b100, "char3");
    checkVal("char3_value", 64'(char_out), 64'h49);
    char_idx = 3'd6;
    stepCycle(3'b100, "char6");
    checkVal("char6_value", 64'(char_out), 64'h20);
`endif

    // Randomized run with frequent repeats so both changed values occur
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 2) == 0) ? mLast : 3'($urandom_range(0, 7));
`ifdef CODIFICADOR_CHAR_PORT_EN
      char_idx = 3'($urandom_range(0, 7));
`endif
      stepCycle(op, "rand");
      if ($urandom_range(0, 60) == 0) begin
        @(negedge clk);
        pulseReset("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
